uart_rx_controller: RTL and testbench
=====================================

# uart_rx_controller

Receive-side sequencer for the UART. Oversamples the serial line, deserializes one frame (start, 8 data bits LSB first, optional parity, stop), presents the captured fields to the error checker (ErrorCheck), and latches data plus error flags into a one-deep output register with a valid/ready handshake and overrun detection.

## Interface
- OVERSAMPLE, 16, baud_tick strobes per bit; even, ≥4.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- baud_tick  in  1  one-cycle oversample strobe.
- rx_serial  in  1  asynchronous serial line, idle high.
- parity_type  in  2  01 odd, 10 even, 00/11 none; sampled at frame start.
- raw_data  out  8  captured data to checker.
- parity_bit / start_bit / stop_bit  out  1 each  captured frame bits to checker.
- recieved_flag  out  1  one-cycle checker enable.
- error_flag  in  3  checker result {stop, start, parity}; combinational, valid in the recieved_flag cycle.
- rx_data  out  8  delivered byte.
- rx_error  out  3  error_flag captured with rx_data.
- rx_valid  out  1  output register full.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
- overrun  out  1  sticky: a completed frame was dropped.

## Operation
- rx_serial passes a 2-flop synchronizer; prev_line holds the previous synchronized value.
- States: IDLE, START, DATA, PARITY, STOP, CHECK.
- IDLE: on synchronized line 0 with prev_line 1 (falling edge) → START, tick_cnt=0, latch parity_type.
- START: count baud_ticks; at tick_cnt==OVERSAMPLE/2-1 sample line. Sample 1 → IDLE (false start, no recieved_flag). Sample 0 → start_bit=0, DATA, tick_cnt=0.
- DATA: sample at tick_cnt==OVERSAMPLE-1, shift into raw_data[7] (LSB first); after 8th sample → PARITY if parity enabled else STOP.
- PARITY: one bit period, sample into parity_bit. With no parity, parity_bit is held 0.
- STOP: one bit period, sample into stop_bit → CHECK.
- CHECK: exactly one clock; recieved_flag=1. If rx_valid=0 or a handshake occurs this cycle: rx_data←raw_data, rx_error←error_flag, rx_valid←1. Otherwise frame dropped, overrun←1. → IDLE.
- Stop bit 0 (break): returns to IDLE; no new frame until line returns high and falls again.
- rx_valid clears on handshake unless reloaded in the same cycle. overrun clears on the next handshake.
- raw_data/frame bits hold their last values outside frames; the checker is qualified only by recieved_flag.

## Timing
- Reset (any state, incl. mid-frame): state IDLE, tick_cnt 0, raw_data 0x00, parity_bit 0, start_bit 0, stop_bit 0, recieved_flag 0, rx_data 0x00, rx_error 000, rx_valid 0, overrun 0, synchronizer flops 1; all values visible the cycle after reset is sampled.
- Edge-detect latency: 2 clocks synchronizer + 1 clock edge compare.
- tick_cnt advances only on baud_tick; wraps at OVERSAMPLE-1 to 0.
- recieved_flag rises the clock after the stop-bit sample; rx_valid rises the clock after recieved_flag.
- Simultaneous CHECK and handshake: new frame loads, no overrun.
- baud_tick ignored in IDLE and CHECK.

## Structure
- Shared package uart_pkg: parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN), rx_state_t enum, error_flag bit indices (ERR_PARITY=0, ERR_START=1, ERR_STOP=2).
- One sub-module: uart_rx_sampler (synchronizer, falling-edge detect, tick counter, mid-bit sample strobe). FSM, shift register, output register and overrun logic stay in uart_rx_controller. ErrorCheck is instantiated beside it at the next level up.

## Test plan
- OVERSAMPLE=16, baud_tick every clock, even parity, frame 0xA5 with parity 0, stop 1 → one recieved_flag pulse, rx_valid=1, rx_data=0xA5, rx_error=000.
- Line low for 4 ticks then high → no recieved_flag, state returns to IDLE, rx_valid stays 0.
- Odd parity, data 0x01, parity bit driven 1 (wrong) → rx_error=001, rx_data=0x01.
- No parity, data 0x3C, stop bit 0, line held low 40 ticks → rx_error=100, exactly one frame reported; next frame 0x55 after line high → rx_data=0x55, rx_error=000.
- rx_ready=0, frames 0x11 then 0x22 → rx_data=0x11, overrun=1; rx_ready=1 one cycle → rx_valid=0, overrun=0.
- Reset asserted during DATA bit 4 → next cycle all outputs at reset values; subsequent frame 0x7E received with rx_error=000.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receive FSM states, error flag bit positions.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_START  = 1;
  localparam int unsigned ERR_STOP   = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_CHECK  = 3'd5
  } rx_state_t;

  // 2'b11 is treated as "no parity", same as PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] pt);
    return (pt == PAR_ODD) || (pt == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchronizer, falling-edge detect,
// oversample tick counter and mid-bit sample strobe.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic baud_tick,
  input  logic rx_serial,
  input  logic cnt_en,
  input  logic half_bit,
  output logic line,
  output logic fall,
  output logic sample
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  logic          sync1_q, sync2_q, prev_line_q;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  assign line   = sync2_q;
  assign fall   = prev_line_q & ~sync2_q;
  assign sample = cnt_en & baud_tick & (tick_cnt_q == (half_bit ? HALF_LAST : FULL_LAST));

  // A sample restarts the bit period so the start-bit half period realigns to bit centres.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!cnt_en) begin
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      if (sample || (tick_cnt_q == FULL_LAST)) tick_cnt_d = '0;
      else                                      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_line_q <= 1'b1;
      tick_cnt_q  <= '0;
    end else begin
      sync1_q     <= rx_serial;
      sync2_q     <= sync1_q;
      prev_line_q <= sync2_q;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: frames the serial line, hands fields to the error checker and
// holds the result in a one-deep valid/ready output register with overrun tracking.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_serial,
  input  logic [1:0] parity_type,
  output logic [7:0] raw_data,
  output logic       parity_bit,
  output logic       start_bit,
  output logic       stop_bit,
  output logic       recieved_flag,
  input  logic [2:0] error_flag,
  output logic [7:0] rx_data,
  output logic [2:0] rx_error,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun
);

  rx_state_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] par_type_q, par_type_d;
  logic [7:0] raw_data_q, raw_data_d;
  logic       parity_bit_q, parity_bit_d;
  logic       start_bit_q, start_bit_d;
  logic       stop_bit_q, stop_bit_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] rx_error_q, rx_error_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;

  logic line, fall, sample, cnt_en, half_bit;
  logic in_check, handshake, load;

  assign cnt_en   = (state_q != S_IDLE) && (state_q != S_CHECK);
  assign half_bit = (state_q == S_START);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clock     (clock),
    .reset     (reset),
    .baud_tick (baud_tick),
    .rx_serial (rx_serial),
    .cnt_en    (cnt_en),
    .half_bit  (half_bit),
    .line      (line),
    .fall      (fall),
    .sample    (sample)
  );

  assign in_check  = (state_q == S_CHECK);
  assign handshake = rx_valid_q & rx_ready;
  // A consumer draining the register in the CHECK cycle frees the slot for the new frame.
  assign load      = in_check & (~rx_valid_q | rx_ready);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    par_type_d   = par_type_q;
    raw_data_d   = raw_data_q;
    parity_bit_d = parity_bit_q;
    start_bit_d  = start_bit_q;
    stop_bit_d   = stop_bit_q;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          par_type_d = parity_type;
          if (!parity_enabled(parity_type)) parity_bit_d = 1'b0;
        end
      end
      S_START: begin
        if (sample) begin
          if (line) begin
            state_d = S_IDLE;
          end else begin
            start_bit_d = 1'b0;
            bit_cnt_d   = '0;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          raw_data_d = {line, raw_data_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = parity_enabled(par_type_q) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          parity_bit_d = line;
          state_d      = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          stop_bit_d = line;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_error_d = rx_error_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (load) begin
      rx_data_d  = raw_data_q;
      rx_error_d = error_flag;
      rx_valid_d = 1'b1;
    end else if (handshake) begin
      rx_valid_d = 1'b0;
    end
    if (in_check && !load) overrun_d = 1'b1;
    else if (handshake)    overrun_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      par_type_q   <= PAR_NONE;
      raw_data_q   <= '0;
      parity_bit_q <= 1'b0;
      start_bit_q  <= 1'b0;
      stop_bit_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_error_q   <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      par_type_q   <= par_type_d;
      raw_data_q   <= raw_data_d;
      parity_bit_q <= parity_bit_d;
      start_bit_q  <= start_bit_d;
      stop_bit_q   <= stop_bit_d;
      rx_data_q    <= rx_data_d;
      rx_error_q   <= rx_error_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign raw_data      = raw_data_q;
  assign parity_bit    = parity_bit_q;
  assign start_bit     = start_bit_q;
  assign stop_bit      = stop_bit_q;
  assign recieved_flag = in_check;
  assign rx_data       = rx_data_q;
  assign rx_error      = rx_error_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: table of frames plus hand-written corner sequences, with a
// scoreboard of expected deliveries popped on each output handshake.
module tb_uart_rx_controller;
  import uart_pkg::*;

  localparam int unsigned OS = 16;

  logic       clock = 1'b0;
  logic       reset, baud_tick, rx_serial, rx_ready;
  logic [1:0] parity_type;
  logic [7:0] raw_data, rx_data;
  logic       parity_bit, start_bit, stop_bit, recieved_flag, rx_valid, overrun;
  logic [2:0] error_flag, rx_error;

  uart_rx_controller #(
    .OVERSAMPLE (OS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .rx_serial     (rx_serial),
    .parity_type   (parity_type),
    .raw_data      (raw_data),
    .parity_bit    (parity_bit),
    .start_bit     (start_bit),
    .stop_bit      (stop_bit),
    .recieved_flag (recieved_flag),
    .error_flag    (error_flag),
    .rx_data       (rx_data),
    .rx_error      (rx_error),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready)
    ,.overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Error checker model, driven from the frame fields the DUT presents.
  logic par_err;
  always_comb begin
    par_err = 1'b0;
    if (parity_type == PAR_EVEN)     par_err = ^{raw_data, parity_bit};
    else if (parity_type == PAR_ODD) par_err = ~(^{raw_data, parity_bit});
  end
  assign error_flag = {~stop_bit, start_bit, par_err};

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] err;
  } exp_t;

  typedef struct {
    logic [1:0] ptype;
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic [2:0] exp_err;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rf_count = 0;
  logic prev_rf = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, counts checker enables.
  always @(negedge clock) begin
    if (reset) begin
      prev_rf    <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (recieved_flag) rf_count++;
      if (rx_valid && !prev_valid) check("valid_after_flag", 32'(prev_rf), 32'd1);
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_delivery", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_error", 32'(rx_error), 32'(e.err));
        end
      end
      prev_rf    <= recieved_flag;
      prev_valid <= rx_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    rx_serial = b;
    tick(len);
  endtask

  task automatic send_frame(input logic [1:0] pt, input logic [7:0] d, input logic bad_par,
                            input logic stop, input int stop_len);
    logic pb;
    parity_type = pt;
    pb = ((pt == PAR_ODD) ? ~(^d) : (^d)) ^ bad_par;
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
    if (pt == PAR_ODD || pt == PAR_EVEN) send_bit(pb, OS);
    send_bit(stop, stop_len);
    rx_serial = 1'b1;
    tick(4);
  endtask

  vec_t vecs[7];
  int   rf_before;

  initial begin
    vecs[0] = '{PAR_EVEN, 8'hA5, 1'b0, 1'b1, 3'b000};
    vecs[1] = '{PAR_ODD,  8'h01, 1'b1, 1'b1, 3'b001};
    vecs[2] = '{PAR_NONE, 8'hC3, 1'b0, 1'b1, 3'b000};
    vecs[3] = '{PAR_EVEN, 8'h07, 1'b0, 1'b1, 3'b000};
    vecs[4] = '{PAR_ODD,  8'hFF, 1'b1, 1'b1, 3'b001};
    vecs[5] = '{2'b11,    8'h3C, 1'b0, 1'b0, 3'b100};
    vecs[6] = '{PAR_EVEN, 8'h80, 1'b1, 1'b0, 3'b101};

    reset = 1'b1; baud_tick = 1'b1; rx_serial = 1'b1; rx_ready = 1'b1; parity_type = PAR_NONE;
    tick(3);
    reset = 1'b0;
    check("reset_outputs",
          32'({raw_data, parity_bit, start_bit, stop_bit, recieved_flag, rx_data, rx_error,
               rx_valid, overrun}), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(S_IDLE));
    tick(5);

    // Table of complete frames with the consumer always ready.
    foreach (vecs[i]) begin
      rf_before = rf_count;
      sb_q.push_back('{data: vecs[i].data, err: vecs[i].exp_err});
      send_frame(vecs[i].ptype, vecs[i].data, vecs[i].bad_par, vecs[i].stop, OS);
      check($sformatf("flag_pulses_v%0d", i), 32'(rf_count - rf_before), 32'd1);
      check($sformatf("sb_drained_v%0d", i), 32'(sb_q.size()), 32'd0);
    end

    // False start: line low for 4 ticks only.
    rf_before = rf_count;
    rx_serial = 1'b0;
    tick(4);
    rx_serial = 1'b1;
    tick(30);
    check("false_start_flags", 32'(rf_count - rf_before), 32'd0);
    check("false_start_state", 32'(dut.state_q), 32'(S_IDLE));
    check("false_start_valid", 32'(rx_valid), 32'd0);

    // Break: stop bit low and line held low, then a clean frame.
    rf_before = rf_count;
    sb_q.push_back('{data: 8'h3C, err: 3'b100});
    send_frame(PAR_NONE, 8'h3C, 1'b0, 1'b0, 40);
    tick(16);
    check("break_one_frame", 32'(rf_count - rf_before), 32'd1);
    sb_q.push_back('{data: 8'h55, err: 3'b000});
    send_frame(PAR_NONE, 8'h55, 1'b0, 1'b1, OS);
    check("after_break_frames", 32'(rf_count - rf_before), 32'd2);
    check("after_break_sb", 32'(sb_q.size()), 32'd0);

    // Overrun: consumer stalled across two frames, second one dropped.
    rx_ready = 1'b0;
    sb_q.push_back('{data: 8'h11, err: 3'b000});
    send_frame(PAR_NONE, 8'h11, 1'b0, 1'b1, OS);
    check("ovr_no_overrun_yet", 32'(overrun), 32'd0);
    send_frame(PAR_NONE, 8'h22, 1'b0, 1'b1, OS);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_flag", 32'(overrun), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
    check("ovr_flag_cleared", 32'(overrun), 32'd0);
    check("ovr_sb", 32'(sb_q.size()), 32'd0);
    rx_ready = 1'b1;
    tick(4);

    // Reset in the middle of data bit 4 of 0x7E, then receive 0x7E cleanly.
    parity_type = PAR_NONE;
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h7E >> i) & 8'h01), OS);
    send_bit(1'b1, 8);
    reset = 1'b1;
    rx_serial = 1'b1;
    tick(1);
    check("midframe_reset_outputs",
          32'({raw_data, parity_bit, start_bit, stop_bit, recieved_flag, rx_data, rx_error,
               rx_valid, overrun}), 32'd0);
    check("midframe_reset_state", 32'(dut.state_q), 32'(S_IDLE));
    reset = 1'b0;
    tick(20);
    rf_before = rf_count;
    sb_q.push_back('{data: 8'h7E, err: 3'b000});
    send_frame(PAR_NONE, 8'h7E, 1'b0, 1'b1, OS);
    check("post_reset_frame", 32'(rf_count - rf_before), 32'd1);
    check("final_sb", 32'(sb_q.size()), 32'd0);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
